// File: rtl/game_pkg.sv
// Shared definitions for the game history block: command encodings and the
// default snapshot width.
package game_pkg;

    localparam int GAME_STATE_W = 134;

    typedef enum logic [1:0] {
        CMD_LOAD   = 2'd0,
        CMD_COMMIT = 2'd1,
        CMD_UNDO   = 2'd2,
        CMD_REDO   = 2'd3
    } cmd_e;

endpackage

// File: rtl/history_ram.sv
// Snapshot storage: DEPTH x STATE_W register array with two write ports and
// one combinational read port.
module history_ram
    import game_pkg::*;
#(
    parameter  int STATE_W = GAME_STATE_W,
    parameter  int DEPTH   = 16,
    localparam int PTR_W   = $clog2(DEPTH)
) (
    input  logic               clk,
    input  logic               we_a_i,
    input  logic [PTR_W-1:0]   addr_a_i,
    input  logic [STATE_W-1:0] data_a_i,
    input  logic               we_b_i,
    input  logic [PTR_W-1:0]   addr_b_i,
    input  logic [STATE_W-1:0] data_b_i,
    input  logic [PTR_W-1:0]   rd_addr_i,
    output logic [STATE_W-1:0] rd_data_o
);

    logic [STATE_W-1:0] mem_q [DEPTH];

    // NOTE: the array has no reset; a slot is only ever read after it was written.
    always_ff @(posedge clk) begin
        if (we_a_i) mem_q[addr_a_i] <= data_a_i;
        if (we_b_i) mem_q[addr_b_i] <= data_b_i;
    end

    assign rd_data_o = mem_q[rd_addr_i];

endmodule

// File: rtl/game_history.sv
// Multi-level undo/redo history of game-state snapshots kept in a circular
// buffer; drives the current state to the core and renderer.
module game_history
    import game_pkg::*;
#(
    parameter  int STATE_W = GAME_STATE_W,
    parameter  int DEPTH   = 16,
    localparam int PTR_W   = $clog2(DEPTH)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               game_state_en,
    input  logic [1:0]         sel,
    input  logic [STATE_W-1:0] game_state_int,
    input  logic [STATE_W-1:0] game_state_bm,
    input  logic [STATE_W-1:0] game_state_mm,
    output logic [STATE_W-1:0] game_state,
    output logic               undo_avail,
    output logic               redo_avail,
    output logic [PTR_W-1:0]   undo_cnt,
    output logic [PTR_W-1:0]   redo_cnt,
    output logic               cmd_rej
);

    localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);
    localparam logic [PTR_W-1:0] UNDO_MAX = PTR_W'(DEPTH - 1);

    cmd_e               cmd;
    logic [PTR_W-1:0]   ptr_q, ptr_d;
    logic [PTR_W-1:0]   undo_q, undo_d;
    logic [PTR_W-1:0]   redo_q, redo_d;
    logic [STATE_W-1:0] state_q, state_d;
    logic               rej_q, rej_d;

    logic               we_a, we_b;
    logic [PTR_W-1:0]   addr_a, addr_b, rd_addr;
    logic [STATE_W-1:0] data_a, rd_data;

    assign cmd     = cmd_e'(sel);
    assign rd_addr = (cmd == CMD_UNDO) ? ptr_q - PTR_ONE : ptr_q + PTR_ONE;

    history_ram #(
        .STATE_W (STATE_W),
        .DEPTH   (DEPTH)
    ) u_ram (
        .clk       (clk),
        .we_a_i    (we_a),
        .addr_a_i  (addr_a),
        .data_a_i  (data_a),
        .we_b_i    (we_b),
        .addr_b_i  (addr_b),
        .data_b_i  (game_state_mm),
        .rd_addr_i (rd_addr),
        .rd_data_o (rd_data)
    );

    // NOTE: every signal gets its hold/default value first, so no path leaves one unassigned (no latches).
    always_comb begin
        ptr_d   = ptr_q;
        undo_d  = undo_q;
        redo_d  = redo_q;
        state_d = state_q;
        rej_d   = 1'b0;
        we_a    = 1'b0;
        we_b    = 1'b0;
        addr_a  = ptr_q;
        addr_b  = ptr_q + PTR_ONE;
        data_a  = game_state_bm;

        if (game_state_en && !rst) begin
            case (cmd)
                CMD_LOAD: begin
                    we_a    = 1'b1;
                    addr_a  = '0;
                    data_a  = game_state_int;
                    ptr_d   = '0;
                    state_d = game_state_int;
                    undo_d  = '0;
                    redo_d  = '0;
                end
                CMD_COMMIT: begin
                    // At saturation ptr+1 is the oldest slot, so it is simply overwritten.
                    we_a    = 1'b1;
                    we_b    = 1'b1;
                    ptr_d   = ptr_q + PTR_ONE;
                    state_d = game_state_mm;
                    undo_d  = (undo_q == UNDO_MAX) ? undo_q : undo_q + PTR_ONE;
                    redo_d  = '0;
                end
                CMD_UNDO: begin
                    if (undo_q != '0) begin
                        ptr_d   = ptr_q - PTR_ONE;
                        state_d = rd_data;
                        undo_d  = undo_q - PTR_ONE;
                        redo_d  = redo_q + PTR_ONE;
                    end else begin
                        rej_d = 1'b1;
                    end
                end
                CMD_REDO: begin
                    if (redo_q != '0) begin
                        ptr_d   = ptr_q + PTR_ONE;
                        state_d = rd_data;
                        redo_d  = redo_q - PTR_ONE;
                        undo_d  = undo_q + PTR_ONE;
                    end else begin
                        rej_d = 1'b1;
                    end
                end
            endcase
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            ptr_q   <= '0;
            undo_q  <= '0;
            redo_q  <= '0;
            state_q <= '0;
            rej_q   <= 1'b0;
        end else begin
            ptr_q   <= ptr_d;
            undo_q  <= undo_d;
            redo_q  <= redo_d;
            state_q <= state_d;
            rej_q   <= rej_d;
        end
    end

    assign game_state = state_q;
    assign undo_cnt   = undo_q;
    assign redo_cnt   = redo_q;
    assign undo_avail = (undo_q != '0);
    assign redo_avail = (redo_q != '0);
    assign cmd_rej    = rej_q;

endmodule

// File: tb/tb_game_history.sv
// Bench for game_history: DEPTH=16 and DEPTH=4 instances share stimulus and are
// compared against a list-of-snapshots reference model.
module tb_game_history;
    import game_pkg::*;

    localparam int SW    = GAME_STATE_W;
    localparam int OBS_W = SW + 11;
    typedef logic [SW-1:0] state_t;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       game_state_en = 1'b0;
    logic [1:0] sel = 2'd0;
    state_t     st_int = '0, st_bm = '0, st_mm = '0;

    state_t     gs16, gs4;
    logic [3:0] uc16, rc16;
    logic [1:0] uc4, rc4;
    logic       ua16, ra16, rj16, ua4, ra4, rj4;

    always #5 clk = ~clk;

    game_history #(.DEPTH(16)) dut16 (
        .clk(clk), .rst(rst), .game_state_en(game_state_en), .sel(sel),
        .game_state_int(st_int), .game_state_bm(st_bm), .game_state_mm(st_mm),
        .game_state(gs16), .undo_avail(ua16), .redo_avail(ra16),
        .undo_cnt(uc16), .redo_cnt(rc16), .cmd_rej(rj16)
    );

    game_history #(.DEPTH(4)) dut4 (
        .clk(clk), .rst(rst), .game_state_en(game_state_en), .sel(sel),
        .game_state_int(st_int), .game_state_bm(st_bm), .game_state_mm(st_mm),
        .game_state(gs4), .undo_avail(ua4), .redo_avail(ra4),
        .undo_cnt(uc4), .redo_cnt(rc4), .cmd_rej(rj4)
    );

    logic [OBS_W-1:0] obs [2];
    assign obs[0] = {gs16, uc16, rc16, ua16, ra16, rj16};
    assign obs[1] = {gs4, 2'b00, uc4, 2'b00, rc4, ua4, ra4, rj4};

    int checks = 0;
    int errors = 0;

    // Reference model: an ordered list of snapshots (oldest first) plus a cursor.
    int     dep [2] = '{16, 4};
    state_t hist [2][17];
    int     len [2];
    int     cur [2];
    logic   rej [2];
    state_t last_mm;

    function automatic logic [OBS_W-1:0] exp_vec(input int k);
        int red;
        red = len[k] - 1 - cur[k];
        return {hist[k][cur[k]], 4'(cur[k]), 4'(red), 1'(cur[k] > 0), 1'(red > 0), rej[k]};
    endfunction

    task automatic model_update(input logic r, input logic en, input logic [1:0] s,
                                input state_t i, input state_t b, input state_t m);
        for (int k = 0; k < 2; k++) begin
            rej[k] = 1'b0;
            if (r) begin
                hist[k][0] = '0; len[k] = 1; cur[k] = 0;
            end else if (en) begin
                case (s)
                    2'd0: begin hist[k][0] = i; len[k] = 1; cur[k] = 0; end
                    2'd1: begin
                        hist[k][cur[k]]     = b;
                        hist[k][cur[k] + 1] = m;
                        cur[k] = cur[k] + 1;
                        len[k] = cur[k] + 1;
                        if (len[k] > dep[k]) begin
                            for (int j = 0; j < len[k] - 1; j++) hist[k][j] = hist[k][j + 1];
                            len[k] = len[k] - 1;
                            cur[k] = cur[k] - 1;
                        end
                    end
                    2'd2: if (cur[k] > 0) cur[k] = cur[k] - 1; else rej[k] = 1'b1;
                    2'd3: if (cur[k] < len[k] - 1) cur[k] = cur[k] + 1; else rej[k] = 1'b1;
                endcase
            end
        end
    endtask

    task automatic drive(input logic r, input logic en, input logic [1:0] s,
                         input state_t i, input state_t b, input state_t m);
        @(negedge clk);
        rst = r; game_state_en = en; sel = s; st_int = i; st_bm = b; st_mm = m;
        @(posedge clk);
        model_update(r, en, s, i, b, m);
        #1;
    endtask

    function automatic state_t rand_state();
        return {6'($urandom), $urandom, $urandom, $urandom, $urandom};
    endfunction

    function automatic state_t step_state(input int step);
        return {6'(step), $urandom, $urandom, $urandom, $urandom};
    endfunction

    task automatic do_load(input state_t v);
        drive(1'b0, 1'b1, 2'd0, v, rand_state(), rand_state());
        last_mm = v;
    endtask

    task automatic do_commit(input int step);
        state_t m;
        m = step_state(step);
        drive(1'b0, 1'b1, 2'd1, rand_state(), last_mm, m);
        last_mm = m;
    endtask

    task automatic do_cmd(input logic [1:0] s);
        drive(1'b0, 1'b1, s, rand_state(), rand_state(), rand_state());
    endtask

    task automatic test_reset();
        drive(1'b1, 1'b0, 2'd0, '0, '0, '0);
        drive(1'b0, 1'b0, 2'd0, '0, '0, '0);
        checks++;
        if (gs16 !== '0 || uc16 !== 4'd0 || rc16 !== 4'd0 || rj16 !== 1'b0 || ua16 !== 1'b0) begin
            errors++;
            $display("FAIL reset: got state %h undo %0d redo %0d rej %b, expected all zero",
                     gs16, uc16, rc16, rj16);
        end
        for (int k = 0; k < 2; k++) begin
            checks++;
            if (obs[k] !== exp_vec(k)) begin
                errors++;
                $display("FAIL reset_model dut%0d: got %h expected %h", dep[k], obs[k], exp_vec(k));
            end
        end
    endtask

    task automatic test_load();
        state_t v;
        v = {6'd0, {32{4'h1}}};
        do_load(v);
        checks++;
        if (gs16 !== v || uc16 !== 4'd0 || rc16 !== 4'd0 || ua16 !== 1'b0) begin
            errors++;
            $display("FAIL load: got state %h undo %0d redo %0d avail %b, expected %h 0 0 0",
                     gs16, uc16, rc16, ua16, v);
        end
        for (int k = 0; k < 2; k++) begin
            checks++;
            if (obs[k] !== exp_vec(k)) begin
                errors++;
                $display("FAIL load_model dut%0d: got %h expected %h", dep[k], obs[k], exp_vec(k));
            end
        end
    endtask

    task automatic test_undo_redo();
        state_t bm;
        do_load(step_state(0));
        bm = step_state(1);
        last_mm = bm;
        do_commit(2);
        do_cmd(2'd2);
        checks++;
        if (gs16 !== bm || uc16 !== 4'd0 || rc16 !== 4'd1 || ra16 !== 1'b1) begin
            errors++;
            $display("FAIL undo_one: got state %h undo %0d redo %0d, expected %h 0 1", gs16, uc16, rc16, bm);
        end
        do_cmd(2'd3);
        checks++;
        if (gs16[SW-1 -: 6] !== 6'd2 || rc16 !== 4'd0 || uc16 !== 4'd1) begin
            errors++;
            $display("FAIL redo_one: got step %0d undo %0d redo %0d, expected 2 1 0", gs16[SW-1 -: 6], uc16, rc16);
        end
        for (int k = 0; k < 2; k++) begin
            checks++;
            if (obs[k] !== exp_vec(k)) begin
                errors++;
                $display("FAIL undo_redo_model dut%0d: got %h expected %h", dep[k], obs[k], exp_vec(k));
            end
        end
    endtask

    task automatic test_saturation();
        do_load(step_state(0));
        for (int s = 1; s <= 5; s++) do_commit(s);
        checks++;
        if (uc4 !== 2'd3 || uc16 !== 4'd5) begin
            errors++;
            $display("FAIL saturate4: got undo %0d/%0d, expected 3/5", uc4, uc16);
        end
        for (int n = 0; n < 4; n++) begin
            do_cmd(2'd2);
            checks++;
            if (gs4[SW-1 -: 6] !== 6'((n < 3) ? 4 - n : 2) || rj4 !== (n == 3)) begin
                errors++;
                $display("FAIL undo_walk4 #%0d: got step %0d rej %b, expected %0d %b",
                         n, gs4[SW-1 -: 6], rj4, (n < 3) ? 4 - n : 2, n == 3);
            end
        end
        do_cmd(2'd0 + 2'd0 == 2'd0 ? 2'd2 : 2'd2);
        drive(1'b0, 1'b0, 2'd2, '0, '0, '0);
        checks++;
        if (rj4 !== 1'b0) begin
            errors++;
            $display("FAIL rej_pulse: got rej %b one cycle after idle, expected 0", rj4);
        end
        // Long run exercises wrap and saturation of the 16-deep instance.
        do_load(step_state(0));
        for (int s = 1; s <= 20; s++) begin
            do_commit(s);
            for (int k = 0; k < 2; k++) begin
                checks++;
                if (obs[k] !== exp_vec(k)) begin
                    errors++;
                    $display("FAIL commit_wrap dut%0d s%0d: got %h expected %h", dep[k], s, obs[k], exp_vec(k));
                end
            end
        end
        for (int n = 0; n < 17; n++) begin
            do_cmd(2'd2);
            for (int k = 0; k < 2; k++) begin
                checks++;
                if (obs[k] !== exp_vec(k)) begin
                    errors++;
                    $display("FAIL undo_wrap dut%0d n%0d: got %h expected %h", dep[k], n, obs[k], exp_vec(k));
                end
            end
        end
    endtask

    task automatic test_branch();
        do_load(step_state(0));
        do_commit(1);
        do_commit(2);
        do_cmd(2'd2);
        do_commit(9);
        checks++;
        if (rc16 !== 4'd0 || gs16[SW-1 -: 6] !== 6'd9 || uc16 !== 4'd2) begin
            errors++;
            $display("FAIL branch: got step %0d undo %0d redo %0d, expected 9 2 0", gs16[SW-1 -: 6], uc16, rc16);
        end
        do_cmd(2'd3);
        checks++;
        if (rj16 !== 1'b1 || gs16[SW-1 -: 6] !== 6'd9) begin
            errors++;
            $display("FAIL branch_redo: got rej %b step %0d, expected 1 9", rj16, gs16[SW-1 -: 6]);
        end
    endtask

    task automatic test_redo_hold();
        do_load(step_state(0));
        do_commit(1);
        do_commit(2);
        do_cmd(2'd2);
        do_cmd(2'd2);
        for (int n = 0; n < 6; n++) begin
            do_cmd(2'd3);
            checks++;
            if (gs4[SW-1 -: 6] !== 6'((n == 0) ? 1 : 2) || rj4 !== (n >= 2)) begin
                errors++;
                $display("FAIL redo_hold #%0d: got step %0d rej %b, expected %0d %b",
                         n, gs4[SW-1 -: 6], rj4, (n == 0) ? 1 : 2, n >= 2);
            end
        end
    endtask

    task automatic test_reset_mid();
        do_load(step_state(0));
        do_commit(1);
        do_commit(2);
        do_cmd(2'd2);
        drive(1'b1, 1'b1, 2'd1, rand_state(), rand_state(), rand_state());
        checks++;
        if (gs16 !== '0 || uc16 !== 4'd0 || rc16 !== 4'd0 || gs4 !== '0 || uc4 !== 2'd0 || rc4 !== 2'd0) begin
            errors++;
            $display("FAIL reset_mid: got state %h undo %0d redo %0d, expected 0 0 0", gs16, uc16, rc16);
        end
    endtask

    task automatic test_idle();
        do_load(step_state(0));
        do_commit(1);
        drive(1'b0, 1'b0, 2'd2, rand_state(), rand_state(), rand_state());
        drive(1'b0, 1'b0, 2'd1, rand_state(), rand_state(), rand_state());
        checks++;
        if (gs16[SW-1 -: 6] !== 6'd1 || uc16 !== 4'd1 || rj16 !== 1'b0) begin
            errors++;
            $display("FAIL idle: got step %0d undo %0d rej %b, expected 1 1 0", gs16[SW-1 -: 6], uc16, rj16);
        end
    endtask

    task automatic test_random();
        logic       r, en;
        logic [1:0] s;
        state_t     b;
        for (int n = 0; n < 500; n++) begin
            r  = ($urandom_range(0, 59) == 0);
            en = ($urandom_range(0, 7) != 0);
            s  = 2'($urandom_range(0, 3));
            if (s == 2'd0 && $urandom_range(0, 2) != 0) s = 2'd1;
            b  = ($urandom_range(0, 3) == 0) ? rand_state() : last_mm;
            drive(r, en, s, rand_state(), b, rand_state());
            last_mm = hist[0][cur[0]];
            for (int k = 0; k < 2; k++) begin
                checks++;
                if (obs[k] !== exp_vec(k)) begin
                    errors++;
                    $display("FAIL random dut%0d cyc%0d: got %h expected %h", dep[k], n, obs[k], exp_vec(k));
                end
            end
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "watchdog expired");
    end

    initial begin
        last_mm = '0;
        test_reset();
        test_load();
        test_undo_redo();
        test_saturation();
        test_branch();
        test_redo_hold();
        test_reset_mid();
        test_idle();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
